// File: rtl/flip_flop_if.sv
// Bus bundle for the flip_flop stage register: write enable, data in, registered data out.
// The flush line exists only when FLIP_FLOP_FLUSH_EN is defined.
interface flip_flop_if #(
    parameter int N = 32
);
    logic         we;
`ifdef FLIP_FLOP_FLUSH_EN
    logic         flush;
`endif
    logic [N-1:0] in;
    logic [N-1:0] out;

    // Handshake: no valid/ready. The register samples we (and flush) together with in
    // on every rising clk edge; out is the state register and only moves at that edge
    // or when reset asserts.
    modport master (
        output we,
`ifdef FLIP_FLOP_FLUSH_EN
        output flush,
`endif
        output in,
        input  out
    );

    modport slave (
        input  we,
`ifdef FLIP_FLOP_FLUSH_EN
        input  flush,
`endif
        input  in,
        output out
    );
endinterface

// File: rtl/flip_flop.sv
// N-bit pipeline stage register with write enable and asynchronous reset to RESET_VALUE.
// Optional synchronous flush (bubble insert) enabled by defining FLIP_FLOP_FLUSH_EN.
module flip_flop #(
    parameter int           N           = 32,
    parameter logic [N-1:0] RESET_VALUE = '0
) (
    input  logic        clk,
    input  logic        reset,
    flip_flop_if.slave  bus
);
    logic [N-1:0] q;

    // Priority is reset > flush > we; with we low the stage simply holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VALUE;
        end
`ifdef FLIP_FLOP_FLUSH_EN
        else if (bus.flush) begin
            q <= RESET_VALUE;
        end
`endif
        else if (bus.we) begin
            q <= bus.in;
        end
    end

    assign bus.out = q;
endmodule

// File: tb/tb_flip_flop.sv
// Self-checking bench for flip_flop: two chained 4-bit stages plus a 32-bit stage with a
// non-zero reset value, directed steps followed by a randomized run against a reference model.
module tb_flip_flop;
    localparam logic [31:0] RV32 = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    flip_flop_if #(.N(4))  if_a ();
    flip_flop_if #(.N(4))  if_b ();
    flip_flop_if #(.N(32)) if_w ();

    assign if_b.in = if_a.out;

    flip_flop #(.N(4)) dut_a (.clk(clk), .reset(reset), .bus(if_a.slave));
    flip_flop #(.N(4)) dut_b (.clk(clk), .reset(reset), .bus(if_b.slave));
    flip_flop #(.N(32), .RESET_VALUE(RV32)) dut_w (.clk(clk), .reset(reset), .bus(if_w.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          hist[$];
        int          exp_c;
        logic [31:0] exp_w;
        logic [31:0] v;
        logic        we_r;
        logic        fl_r;

        reset    = 1'b1;
        if_a.we  = 1'b1;
        if_a.in  = 4'hF;
        if_b.we  = 1'b1;
        if_w.we  = 1'b0;
        if_w.in  = '0;
`ifdef FLIP_FLOP_FLUSH_EN
        if_a.flush = 1'b0;
        if_b.flush = 1'b0;
        if_w.flush = 1'b0;
`endif
        fl_r = 1'b0;
        #1;
        check("reset_a_t0", if_a.out, 32'h0);
        check("reset_w_t0", if_w.out, RV32);
        for (int i = 0; i < 2; i++) begin
            step();
            check("reset_hold_a", if_a.out, 32'h0);
        end

        // Deassert between edges: nothing changes until the next edge.
        reset = 1'b0;
        #2;
        check("deassert_no_change", if_a.out, 32'h0);
        step();
        check("first_capture_a", if_a.out, 32'hF);
        check("chain_pre_edge_b", if_b.out, 32'h0);

        // Asynchronous reset mid-cycle.
        if_a.in = 4'h5;
        step();
        check("capture_5", if_a.out, 32'h5);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_a", if_a.out, 32'h0);
        check("async_reset_b", if_b.out, 32'h0);
        check("async_reset_w", if_w.out, RV32);
        #1;
        reset = 1'b0;

        // Chain: stage B lags A by one edge.
        hist.push_back(0);
        for (int i = 1; i <= 6; i++) begin
            if_a.in = 4'(i);
            step();
            exp_c = hist[$];
            hist.push_back(i);
            check("chain_b", if_a.out, 32'(i));
            check("chain_c", if_b.out, 32'(exp_c));
        end

        // Write-enable hold.
        if_a.in = 4'h3;
        step();
        if_a.we = 1'b0;
        if_a.in = 4'h9;
        for (int i = 0; i < 3; i++) begin
            step();
            check("we_hold", if_a.out, 32'h3);
        end
        if_a.we = 1'b1;
        step();
        check("we_resume", if_a.out, 32'h9);

        // Mid-cycle input changes are not propagated.
        if_a.in = 4'h1;
        step();
        check("mid_capture_1", if_a.out, 32'h1);
        if_a.in = 4'h7;
        #2;
        check("mid_no_7", if_a.out, 32'h1);
        if_a.in = 4'h2;
        #2;
        check("mid_no_2_yet", if_a.out, 32'h1);
        step();
        check("mid_capture_2", if_a.out, 32'h2);

        // 32-bit width and reset value.
        check("w_still_rv", if_w.out, RV32);
        if_w.we = 1'b1;
        if_w.in = 32'h0000_0001;
        step();
        check("w_capture_1", if_w.out, 32'h0000_0001);

`ifdef FLIP_FLOP_FLUSH_EN
        if_a.in = 4'h6;
        step();
        check("flush_pre_6", if_a.out, 32'h6);
        if_a.flush = 1'b1;
        if_a.in    = 4'hA;
        step();
        check("flush_bubble", if_a.out, 32'h0);
        if_a.flush = 1'b0;
        step();
        check("flush_resume_A", if_a.out, 32'hA);
`endif

        // Randomized run on the 32-bit stage against a reference model.
        exp_w = 32'h0000_0001;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                reset = 1'b1;
                #1;
                exp_w = RV32;
                check("rand_async_reset", if_w.out, exp_w);
                reset = 1'b0;
            end
            we_r = 1'($urandom_range(0, 1));
            v    = $urandom;
`ifdef FLIP_FLOP_FLUSH_EN
            fl_r = ($urandom_range(0, 7) == 0);
            if_w.flush = fl_r;
`endif
            if_w.we = we_r;
            if_w.in = $urandom;
            #1;
            if_w.in = v;
            check("rand_no_comb_path", if_w.out, exp_w);
            if (fl_r) exp_w = RV32;
            else if (we_r) exp_w = v;
            step();
            check("rand_edge", if_w.out, exp_w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
